sequencer: RTL and testbench

//  Control-unit FSM for the basic 8-bit processor. Drives the per-cycle control

---
 rtl/sequencer.sv | 157 +++++++++++++++
 tb/tb_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sequencer.sv
// Control-unit FSM for the basic 8-bit processor.
// Sequences fetch/decode/execute strobes for PC, IR, ACC/ALU and memory.
module sequencer #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3
) (
   input  logic            clock,
   input  logic            n_reset,
   input  logic [OP_W-1:0] op,
   input  logic            z_flag,
   input  logic            mem_wait,
   output logic            ACC_bus,
   output logic            load_ACC,
   output logic            PC_bus,
   output logic            load_PC,
   output logic            INC_PC,
   output logic            load_IR,
   output logic            Addr_bus,
   output logic            load_MAR,
   output logic            MDR_bus,
   output logic            load_MDR,
   output logic            CS,
   output logic            R_NW,
   output logic            ALU_ACC,
   output logic            ALU_add,
   output logic            ALU_sub
);

   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);

   typedef enum logic [3:0] {
      FETCH0, FETCH1, FETCH2, DECODE,
      RD0, RD1, ST0, ST1, BR0
   } state_t;

   typedef struct packed {
      logic acc_bus;
      logic load_acc;
      logic pc_bus;
      logic load_pc;
      logic inc_pc;
      logic load_ir;
      logic addr_bus;
      logic load_mar;
      logic mdr_bus;
      logic load_mdr;
      logic cs;
      logic r_nw;
      logic alu_acc;
      logic alu_add;
      logic alu_sub;
   } ctl_t;

   state_t state_q, state_d;
   ctl_t   ctl_q;

   // Outputs are registered from the decode of the state being entered,
   // so they always match the current state without a decode after the flops.
   function automatic ctl_t decode(input state_t s, input logic [OP_W-1:0] o);
      ctl_t c;
      c = '0;
      case (s)
         FETCH0: begin
            c.pc_bus   = 1'b1;
            c.load_mar = 1'b1;
            c.inc_pc   = 1'b1;
            c.load_pc  = 1'b1;
         end
         FETCH1, RD0: begin
            c.cs   = 1'b1;
            c.r_nw = 1'b1;
         end
         FETCH2: begin
            c.mdr_bus = 1'b1;
            c.load_ir = 1'b1;
         end
         DECODE: begin
            c.addr_bus = 1'b1;
            c.load_mar = 1'b1;
         end
         RD1: begin
            c.mdr_bus  = 1'b1;
            c.load_acc = 1'b1;
            c.alu_acc  = (o == OP_ADD) || (o == OP_SUB);
            c.alu_add  = (o == OP_ADD);
            c.alu_sub  = (o == OP_SUB);
         end
         ST0: begin
            c.acc_bus  = 1'b1;
            c.load_mdr = 1'b1;
         end
         ST1: c.cs = 1'b1;
         BR0: begin
            c.addr_bus = 1'b1;
            c.load_pc  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = FETCH0;
      case (state_q)
         FETCH0: state_d = FETCH1;
         FETCH1: state_d = mem_wait ? FETCH1 : FETCH2;
         FETCH2: state_d = DECODE;
         DECODE: begin
            if (op == OP_STORE)
               state_d = ST0;
            else if (op == OP_LOAD || op == OP_ADD || op == OP_SUB)
               state_d = RD0;
            else if (op == OP_BNE && !z_flag)
               state_d = BR0;
            else
               state_d = FETCH0;
         end
         RD0:     state_d = mem_wait ? RD0 : RD1;
         RD1:     state_d = FETCH0;
         ST0:     state_d = ST1;
         ST1:     state_d = mem_wait ? ST1 : FETCH0;
         BR0:     state_d = FETCH0;
         default: state_d = FETCH0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state_q <= FETCH0;
         ctl_q   <= decode(FETCH0, op);
      end else begin
         state_q <= state_d;
         ctl_q   <= decode(state_d, op);
      end
   end

   assign ACC_bus  = ctl_q.acc_bus;
   assign load_ACC = ctl_q.load_acc;
   assign PC_bus   = ctl_q.pc_bus;
   assign load_PC  = ctl_q.load_pc;
   assign INC_PC   = ctl_q.inc_pc;
   assign load_IR  = ctl_q.load_ir;
   assign Addr_bus = ctl_q.addr_bus;
   assign load_MAR = ctl_q.load_mar;
   assign MDR_bus  = ctl_q.mdr_bus;
   assign load_MDR = ctl_q.load_mdr;
   assign CS       = ctl_q.cs;
   assign R_NW     = ctl_q.r_nw;
   assign ALU_ACC  = ctl_q.alu_acc;
   assign ALU_add  = ctl_q.alu_add;
   assign ALU_sub  = ctl_q.alu_sub;

endmodule

// File: tb/tb_sequencer.sv
// Bench for sequencer: per-cycle strobe vectors from an instruction-level
// model, with random waits, random don't-care inputs and reset aborts.
module tb_sequencer;

   localparam logic [2:0] LOAD  = 3'd0;
   localparam logic [2:0] STORE = 3'd1;
   localparam logic [2:0] ADD   = 3'd2;
   localparam logic [2:0] SUB   = 3'd3;
   localparam logic [2:0] BNE   = 3'd4;

   // bit order: ACC_bus load_ACC PC_bus load_PC INC_PC load_IR Addr_bus
   //            load_MAR MDR_bus load_MDR CS R_NW ALU_ACC ALU_add ALU_sub
   localparam logic [14:0] B_ACCB = 15'h4000;
   localparam logic [14:0] B_LACC = 15'h2000;
   localparam logic [14:0] B_PCB  = 15'h1000;
   localparam logic [14:0] B_LPC  = 15'h0800;
   localparam logic [14:0] B_INC  = 15'h0400;
   localparam logic [14:0] B_LIR  = 15'h0200;
   localparam logic [14:0] B_ADRB = 15'h0100;
   localparam logic [14:0] B_LMAR = 15'h0080;
   localparam logic [14:0] B_MDRB = 15'h0040;
   localparam logic [14:0] B_LMDR = 15'h0020;
   localparam logic [14:0] B_CS   = 15'h0010;
   localparam logic [14:0] B_RNW  = 15'h0008;
   localparam logic [14:0] B_AACC = 15'h0004;
   localparam logic [14:0] B_ADD  = 15'h0002;
   localparam logic [14:0] B_SUB  = 15'h0001;

   localparam logic [14:0] V_FETCH = B_PCB | B_LMAR | B_INC | B_LPC;
   localparam logic [14:0] V_MRD   = B_CS | B_RNW;
   localparam logic [14:0] V_IR    = B_MDRB | B_LIR;
   localparam logic [14:0] V_DEC   = B_ADRB | B_LMAR;
   localparam logic [14:0] V_STD   = B_ACCB | B_LMDR;
   localparam logic [14:0] V_MWR   = B_CS;
   localparam logic [14:0] V_BR    = B_ADRB | B_LPC;

   logic clock = 1'b0;
   logic n_reset, z_flag, mem_wait;
   logic [2:0] op;
   logic ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus;
   logic load_MAR, MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add, ALU_sub;

   int checks = 0;
   int errors = 0;

   logic [14:0] expq[$];
   int          wq[$];

   sequencer #(.WORD_W(8), .OP_W(3)) dut (
      .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag),
      .mem_wait(mem_wait), .ACC_bus(ACC_bus), .load_ACC(load_ACC),
      .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC),
      .load_IR(load_IR), .Addr_bus(Addr_bus), .load_MAR(load_MAR),
      .MDR_bus(MDR_bus), .load_MDR(load_MDR), .CS(CS), .R_NW(R_NW),
      .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub)
   );

   always #5 clock = ~clock;

   wire logic [14:0] obs = {ACC_bus, load_ACC, PC_bus, load_PC, INC_PC,
      load_IR, Addr_bus, load_MAR, MDR_bus, load_MDR, CS, R_NW,
      ALU_ACC, ALU_add, ALU_sub};

   task automatic chk(input string tag, input logic [14:0] o,
                      input logic [14:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic chk_rules(input string tag);
      logic ok;
      ok = ($countones({ACC_bus, PC_bus, Addr_bus, MDR_bus}) <= 1) &&
           !(ALU_add && ALU_sub) && !(load_MDR && CS && R_NW);
      chk({tag, "_rules"}, {14'd0, ok}, 15'd1);
   endtask

   // wait code: 1/0 = mem_wait value in a memory cycle, 2 = don't care
   task automatic push(input logic [14:0] v, input int w);
      expq.push_back(v);
      wq.push_back(w);
   endtask

   task automatic build(input logic [2:0] o, input logic z,
                        input int fw, input int ew);
      expq.delete();
      wq.delete();
      push(V_FETCH, 2);
      repeat (fw) push(V_MRD, 1);
      push(V_MRD, 0);
      push(V_IR, 2);
      push(V_DEC, 2);
      case (o)
         STORE: begin
            push(V_STD, 2);
            repeat (ew) push(V_MWR, 1);
            push(V_MWR, 0);
         end
         LOAD, ADD, SUB: begin
            repeat (ew) push(V_MRD, 1);
            push(V_MRD, 0);
            push(B_MDRB | B_LACC |
                 (o == ADD ? (B_AACC | B_ADD) : 15'd0) |
                 (o == SUB ? (B_AACC | B_SUB) : 15'd0), 2);
         end
         BNE: if (z === 1'b0) push(V_BR, 2);
         default: ;
      endcase
   endtask

   // abort >= 0: pull n_reset low at that cycle of the instruction
   task automatic run(input string tag, input logic [2:0] o, input logic z,
                      input int fw, input int ew, input int abort);
      build(o, z, fw, ew);
      op = o;
      for (int i = 0; i < expq.size(); i++) begin
         chk($sformatf("%s_c%0d", tag, i), obs, expq[i]);
         chk_rules(tag);
         mem_wait = (wq[i] == 2) ? 1'($urandom) : 1'(wq[i]);
         z_flag   = (expq[i] == V_DEC) ? z : 1'($urandom);
         if (i == abort) begin
            n_reset = 1'b0;
            @(posedge clock);
            #1;
            n_reset = 1'b1;
            chk({tag, "_abort"}, obs, V_FETCH);
            return;
         end
         @(posedge clock);
         #1;
      end
      chk({tag, "_end"}, obs, V_FETCH);
   endtask

   initial begin
      n_reset  = 1'b0;
      op       = 3'd0;
      z_flag   = 1'b0;
      mem_wait = 1'b1;
      @(posedge clock);
      #1;
      n_reset = 1'b1;
      chk("reset", obs, V_FETCH);

      run("add",    ADD,   1'bx, 0, 0, -1);
      run("sub",    SUB,   1'b1, 0, 0, -1);
      run("store",  STORE, 1'b0, 0, 0, -1);
      run("bne_t",  BNE,   1'b0, 0, 0, -1);
      run("bne_nt", BNE,   1'b1, 0, 0, -1);
      run("nop5",   3'd5,  1'b0, 0, 0, -1);
      run("nop6",   3'd6,  1'b1, 1, 0, -1);
      run("nop7",   3'd7,  1'b0, 0, 0, -1);
      run("ld_wait", LOAD, 1'b0, 2, 3, -1);
      run("st_wait", STORE, 1'b1, 1, 2, -1);
      run("rst_rd0", LOAD, 1'b0, 0, 2, 4);
      run("rst_st1", STORE, 1'b0, 0, 3, 6);

      run("p_load",  LOAD,  1'b0, 1, 1, -1);
      run("p_add",   ADD,   1'b0, 0, 2, -1);
      run("p_store", STORE, 1'b0, 2, 0, -1);
      run("p_bne",   BNE,   1'b0, 0, 0, -1);

      for (int k = 0; k < 60; k++) begin
         automatic logic [2:0] ro = 3'($urandom_range(0, 7));
         automatic logic       rz = 1'($urandom);
         automatic int         rf = int'($urandom_range(0, 3));
         automatic int         re = int'($urandom_range(0, 3));
         automatic int         ra = ($urandom_range(0, 9) == 0) ?
                                    int'($urandom_range(0, 5)) : -1;
         run($sformatf("rnd%0d", k), ro, rz, rf, re, ra);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
